// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    VEXEC = 1'b1
  } pipe_state_e;

  localparam int unsigned MC_OP_BIT     = 4;
  localparam int unsigned DEFAULT_LANES = 4;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] MaxCount = {CW{1'b1}};

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_inc && (r_count != MaxCount)) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush generation for the five-stage vector pipeline, including the
// lane sequencer that holds multi-cycle vector ALU ops in E.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned LANES = DEFAULT_LANES,
  parameter int unsigned LW    = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [M-1:0]  regAD,
  input  logic [M-1:0]  regBD,
  input  logic          useA_D,
  input  logic          useB_D,
  input  logic [M-1:0]  regScr_E,
  input  logic          regw_E,
  input  logic          regmem_E,
  input  logic          vect_E,
  input  logic          ALUope_E,
  input  logic          branch_E,
  input  logic          taken_E,
  input  logic [4:0]    op_code_E,
  input  logic          mem_req_M,
  input  logic          mem_ready,
  input  logic          cnt_clr,
  output logic          stall_F,
  output logic          stall_D,
  output logic          stall_E,
  output logic          stall_M,
  output logic          flush_D,
  output logic          flush_E,
  output logic          flush_M,
  output logic [LW-1:0] lane_E,
  output logic          vbusy,
  output logic [CW-1:0] stall_cnt
);

  localparam logic          MultiLane = logic'(LANES > 1);
  localparam logic [LW-1:0] LastLane  = LW'(LANES - 1);

  pipe_state_e   r_state, w_state_nxt;
  logic [LW-1:0] r_lane, w_lane_nxt;

  logic w_mem_wait, w_mc, w_lu, w_bt;

  assign w_mem_wait = mem_req_M & ~mem_ready;
  assign w_mc       = vect_E & ALUope_E & op_code_E[MC_OP_BIT] & MultiLane;
  assign w_lu       = regmem_E & regw_E &
                      ((useA_D & (regAD == regScr_E)) | (useB_D & (regBD == regScr_E)));
  assign w_bt       = branch_E & taken_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  // A freeze holds the sequencer in place, stretching the op cycle for cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    if (!w_mem_wait) begin
      unique case (r_state)
        RUN: begin
          if (w_mc) begin
            w_state_nxt = VEXEC;
            w_lane_nxt  = LW'(1);
          end
        end
        VEXEC: begin
          if (r_lane < LastLane) begin
            w_lane_nxt = r_lane + 1'b1;
          end else begin
            w_state_nxt = RUN;
            w_lane_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_lane_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    lane_E  = r_lane;
    vbusy   = (r_state == VEXEC) | ((r_state == RUN) & w_mc & ~w_mem_wait);

    if (w_mem_wait) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else if (r_state == VEXEC) begin
      // The last lane releases E so the finished result moves into M.
      if (r_lane < LastLane) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        flush_M = 1'b1;
      end
    end else if (w_mc) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      flush_M = 1'b1;
      lane_E  = '0;
    end else if (w_bt) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (w_lu) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end

    if (!rst) begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_M = 1'b0;
      lane_E  = '0;
      vbusy   = 1'b0;
    end
  end

  sat_counter #(
    .CW (CW)
  ) u_stall_cnt (
    .clk     (clk),
    .i_rst_n (rst),
    .i_inc   (stall_D),
    .i_clr   (cnt_clr),
    .o_count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with LANES = 4 and a 4-bit stall counter.
module tb_pipe_ctrl;

  localparam int unsigned M     = 4;
  localparam int unsigned LANES = 4;
  localparam int unsigned LW    = 2;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [M-1:0]  regAD, regBD, regScr_E;
  logic          useA_D, useB_D, regw_E, regmem_E, vect_E, ALUope_E;
  logic          branch_E, taken_E, mem_req_M, mem_ready, cnt_clr;
  logic [4:0]    op_code_E;
  logic          stall_F, stall_D, stall_E, stall_M;
  logic          flush_D, flush_E, flush_M, vbusy;
  logic [LW-1:0] lane_E;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .M     (M),
    .LANES (LANES),
    .LW    (LW),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .regAD     (regAD),
    .regBD     (regBD),
    .useA_D    (useA_D),
    .useB_D    (useB_D),
    .regScr_E  (regScr_E),
    .regw_E    (regw_E),
    .regmem_E  (regmem_E),
    .vect_E    (vect_E),
    .ALUope_E  (ALUope_E),
    .branch_E  (branch_E),
    .taken_E   (taken_E),
    .op_code_E (op_code_E),
    .mem_req_M (mem_req_M),
    .mem_ready (mem_ready),
    .cnt_clr   (cnt_clr),
    .stall_F   (stall_F),
    .stall_D   (stall_D),
    .stall_E   (stall_E),
    .stall_M   (stall_M),
    .flush_D   (flush_D),
    .flush_E   (flush_E),
    .flush_M   (flush_M),
    .lane_E    (lane_E),
    .vbusy     (vbusy),
    .stall_cnt (stall_cnt)
  );

  // Packed as {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, vbusy}.
  function automatic logic [7:0] ctl();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, vbusy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    regAD = '0; regBD = '0; regScr_E = '0; useA_D = 0; useB_D = 0;
    regw_E = 0; regmem_E = 0; vect_E = 0; ALUope_E = 0; branch_E = 0;
    taken_E = 0; op_code_E = '0; mem_req_M = 0; mem_ready = 1; cnt_clr = 0;
  endtask

  task automatic set_mc(input logic on);
    vect_E = on; ALUope_E = on; op_code_E = on ? 5'b10011 : 5'b00000;
  endtask

  task automatic set_lu();
    regmem_E = 1; regw_E = 1; regScr_E = 4'd5; regAD = 4'd5; useA_D = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    #3;
    chk("reset_ctl", 32'(ctl()), 32'h00);
    chk("reset_lane", 32'(lane_E), 0);
    chk("reset_cnt", 32'(stall_cnt), 0);
    step();
    rst = 1;
    step();

    // Test 1: reset in the middle of a multi-cycle op
    set_mc(1);
    settle(); chk("t1_lane0", 32'(lane_E), 0);
    step(); step();
    settle(); chk("t1_lane2", 32'(lane_E), 2);
    chk("t1_ctl_lane2", 32'(ctl()), 32'hE3);
    rst = 0;
    #1;
    chk("t1_rst_ctl", 32'(ctl()), 32'h00);
    chk("t1_rst_lane", 32'(lane_E), 0);
    chk("t1_rst_cnt", 32'(stall_cnt), 0);
    set_mc(0);
    step();
    rst = 1;
    step();
    settle(); chk("t1_post_ctl", 32'(ctl()), 32'h00);
    chk("t1_post_lane", 32'(lane_E), 0);
    step();
    settle(); chk("t1_post2_ctl", 32'(ctl()), 32'h00);

    // Test 2: full multi-cycle op
    step();
    set_mc(1);
    settle(); chk("t2_c0_ctl", 32'(ctl()), 32'hE3); chk("t2_c0_lane", 32'(lane_E), 0);
    step();
    settle(); chk("t2_c1_ctl", 32'(ctl()), 32'hE3); chk("t2_c1_lane", 32'(lane_E), 1);
    step();
    settle(); chk("t2_c2_ctl", 32'(ctl()), 32'hE3); chk("t2_c2_lane", 32'(lane_E), 2);
    step();
    set_mc(0);
    settle(); chk("t2_c3_ctl", 32'(ctl()), 32'h01); chk("t2_c3_lane", 32'(lane_E), 3);
    chk("t2_cnt_c3", 32'(stall_cnt), 3);
    step();
    settle(); chk("t2_done_ctl", 32'(ctl()), 32'h00); chk("t2_done_lane", 32'(lane_E), 0);
    chk("t2_cnt", 32'(stall_cnt), 3);

    // Test 3: load-use bubble, then the same load with no reader
    set_lu();
    settle(); chk("t3_lu_ctl", 32'(ctl()), 32'hC4);
    step();
    regmem_E = 0;
    settle(); chk("t3_after_ctl", 32'(ctl()), 32'h00);
    chk("t3_cnt", 32'(stall_cnt), 4);
    set_lu(); useA_D = 0;
    settle(); chk("t3_noA_ctl", 32'(ctl()), 32'h00);
    regBD = 4'd5; useB_D = 1;
    settle(); chk("t3_B_ctl", 32'(ctl()), 32'hC4);
    regBD = 4'd6;
    settle(); chk("t3_Bmiss_ctl", 32'(ctl()), 32'h00);

    // Test 4: taken branch squashes a load-use dependent
    set_lu(); branch_E = 1; taken_E = 1;
    settle(); chk("t4_bt_ctl", 32'(ctl()), 32'h0C);
    taken_E = 0;
    settle(); chk("t4_nt_ctl", 32'(ctl()), 32'hC4);
    step();
    idle();

    // Test 5: memory wait while at lane 1
    mem_req_M = 1; mem_ready = 0; set_mc(1);
    settle(); chk("t5_run_frz_ctl", 32'(ctl()), 32'hF0);
    mem_req_M = 0; mem_ready = 1;
    settle(); chk("t5_c0_ctl", 32'(ctl()), 32'hE3);
    step();
    settle(); chk("t5_c1_lane", 32'(lane_E), 1);
    mem_req_M = 1; mem_ready = 0;
    settle(); chk("t5_frz1_ctl", 32'(ctl()), 32'hF1);
    step();
    settle(); chk("t5_frz2_ctl", 32'(ctl()), 32'hF1); chk("t5_frz2_lane", 32'(lane_E), 1);
    step();
    mem_req_M = 0; mem_ready = 1;
    settle(); chk("t5_res_lane", 32'(lane_E), 1); chk("t5_res_ctl", 32'(ctl()), 32'hE3);
    step();
    settle(); chk("t5_lane2", 32'(lane_E), 2);
    step();
    set_mc(0);
    settle(); chk("t5_lane3", 32'(lane_E), 3); chk("t5_lane3_ctl", 32'(ctl()), 32'h01);
    step();
    settle(); chk("t5_done_ctl", 32'(ctl()), 32'h00);

    // Test 6: counter saturation and clear priority
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    settle(); chk("t6_clr0", 32'(stall_cnt), 0);
    set_lu();
    for (int i = 0; i < 20; i++) step();
    settle(); chk("t6_sat", 32'(stall_cnt), 15); chk("t6_sd", 32'(stall_D), 1);
    cnt_clr = 1;
    step();
    settle(); chk("t6_clr", 32'(stall_cnt), 0);
    cnt_clr = 0;
    step();
    settle(); chk("t6_inc", 32'(stall_cnt), 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
